// File: rtl/event_stats_bank.sv
// Bank of per-channel event counters with sticky overflow flags and an
// atomic snapshot (optionally read-and-clear) of all live counts.
module event_stats_bank #(
  parameter int NCH      = 4,
  parameter int CW       = 8,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    ev,
  input  logic              en,
  input  logic [NCH-1:0]    clr,
  input  logic              snap,
  input  logic              snap_clr,
  output logic [NCH*CW-1:0] live,
  output logic [NCH*CW-1:0] shot,
  output logic [NCH-1:0]    ovf,
  output logic              shot_vld,
  output logic              shot_stb
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic wipe;
  logic shot_vld_reg;
  logic shot_stb_reg;

  assign wipe = snap & snap_clr;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;
      logic [CW-1:0] shot_reg;
      logic          ovf_reg;
      logic          ovf_next;
      logic          inc;

      assign inc = ev[gi] & en;

      // A clear (per-channel or snapshot wipe) still admits this cycle's event.
      always_comb begin
        cnt_next = cnt_reg;
        ovf_next = ovf_reg;
        if (clr[gi] || wipe) begin
          cnt_next = inc ? CNT_ONE : '0;
          if (clr[gi]) ovf_next = 1'b0;
        end else if (inc) begin
          if (cnt_reg == CNT_MAX) begin
            ovf_next = 1'b1;
            if (SATURATE == 0) cnt_next = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
      end

      // Snapshot captures the pre-update value, so a snap-cycle event lands only in live.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg  <= '0;
          ovf_reg  <= 1'b0;
          shot_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
          ovf_reg <= ovf_next;
          if (snap) shot_reg <= cnt_reg;
        end
      end

      assign live[gi*CW +: CW] = cnt_reg;
      assign shot[gi*CW +: CW] = shot_reg;
      assign ovf[gi]           = ovf_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shot_vld_reg <= 1'b0;
      shot_stb_reg <= 1'b0;
    end else begin
      shot_stb_reg <= snap;
      if (snap) shot_vld_reg <= 1'b1;
    end
  end

  assign shot_vld = shot_vld_reg;
  assign shot_stb = shot_stb_reg;

endmodule

// File: tb/tb_event_stats_bank.sv
// Scoreboard bench for event_stats_bank: a cycle model predicts every output
// after each edge; small CW=4 instances cover wrap versus saturate.
module tb_event_stats_bank;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // main instance: NCH=4, CW=8, wrapping
  logic [3:0]  ev = '0, clr = '0;
  logic        en = 1'b0, snap = 1'b0, snap_clr = 1'b0;
  logic [31:0] live, shot;
  logic [3:0]  ovf;
  logic        shot_vld, shot_stb;

  event_stats_bank #(.NCH(4), .CW(8), .SATURATE(0)) dut (
    .clk(clk), .rst(rst), .ev(ev), .en(en), .clr(clr), .snap(snap), .snap_clr(snap_clr),
    .live(live), .shot(shot), .ovf(ovf), .shot_vld(shot_vld), .shot_stb(shot_stb)
  );

  // small instances: CW=4, wrap and saturate, sharing stimulus
  logic [3:0]  sev = '0, sclr = '0;
  logic        sen = 1'b0, ssnap = 1'b0, ssnap_clr = 1'b0;
  logic [15:0] w_live, w_shot, s_live, s_shot;
  logic [3:0]  w_ovf, s_ovf;
  logic        w_vld, w_stb, s_vld, s_stb;

  event_stats_bank #(.NCH(4), .CW(4), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .ev(sev), .en(sen), .clr(sclr), .snap(ssnap), .snap_clr(ssnap_clr),
    .live(w_live), .shot(w_shot), .ovf(w_ovf), .shot_vld(w_vld), .shot_stb(w_stb)
  );

  event_stats_bank #(.NCH(4), .CW(4), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .ev(sev), .en(sen), .clr(sclr), .snap(ssnap), .snap_clr(ssnap_clr),
    .live(s_live), .shot(s_shot), .ovf(s_ovf), .shot_vld(s_vld), .shot_stb(s_stb)
  );

  typedef struct packed {
    logic [31:0] live;
    logic [31:0] shot;
    logic [3:0]  ovf;
    logic        vld;
    logic        stb;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int m_live[4];
  int m_shot[4];
  bit m_ovf[4];
  bit m_vld, m_stb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_pack();
    exp_t x;
    for (int i = 0; i < 4; i++) begin
      x.live[i*8 +: 8] = 8'(m_live[i]);
      x.shot[i*8 +: 8] = 8'(m_shot[i]);
      x.ovf[i]         = m_ovf[i];
    end
    x.vld = m_vld;
    x.stb = m_stb;
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_live[i] = 0;
      m_shot[i] = 0;
      m_ovf[i]  = 1'b0;
    end
    m_vld = 1'b0;
    m_stb = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] e, input logic n, input logic [3:0] c,
                            input logic s, input logic sc);
    int old[4];
    for (int i = 0; i < 4; i++) old[i] = m_live[i];
    for (int i = 0; i < 4; i++) begin
      bit hit;
      hit = e[i] && n;
      if (c[i] || (s && sc)) begin
        m_live[i] = hit ? 1 : 0;
        if (c[i]) m_ovf[i] = 1'b0;
      end else if (hit) begin
        m_live[i] = (m_live[i] + 1) % 256;
        if (m_live[i] == 0) m_ovf[i] = 1'b1;
      end
    end
    if (s) begin
      for (int i = 0; i < 4; i++) m_shot[i] = old[i];
      m_vld = 1'b1;
    end
    m_stb = s;
  endtask

  // Drive one cycle, push the prediction, compare after the edge.
  task automatic cycle(input logic [3:0] e, input logic n, input logic [3:0] c,
                       input logic s, input logic sc);
    exp_t x;
    ev = e; en = n; clr = c; snap = s; snap_clr = sc;
    model_step(e, n, c, s, sc);
    sb_q.push_back(model_pack());
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    $display("cyc ev=%b en=%b clr=%b snap=%b sc=%b live=%h shot=%h ovf=%b vld=%b stb=%b",
             e, n, c, s, sc, live, shot, ovf, shot_vld, shot_stb);
    check("live", 64'(live), 64'(x.live));
    check("shot", 64'(shot), 64'(x.shot));
    check("ovf", 64'(ovf), 64'(x.ovf));
    check("shot_vld", 64'(shot_vld), 64'(x.vld));
    check("shot_stb", 64'(shot_stb), 64'(x.stb));
    ev = '0; clr = '0; snap = 1'b0; snap_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // asynchronous reset, checked before any clock edge
    #2 rst = 1'b1;
    #2;
    check("rst_live", 64'(live), 64'd0);
    check("rst_shot", 64'(shot), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_vld", 64'(shot_vld), 64'd0);
    check("rst_stb", 64'(shot_stb), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // basic count on ch0
    for (int k = 0; k < 10; k++) cycle(4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0);
    check("cnt10_ch0", 64'(live[7:0]), 64'd10);
    check("cnt10_rest", 64'(live[31:8]), 64'd0);
    check("cnt10_ovf", 64'(ovf), 64'd0);

    // 8-bit wrap on ch3, then clear drops ovf
    for (int k = 0; k < 256; k++) cycle(4'b1000, 1'b1, 4'b0000, 1'b0, 1'b0);
    check("wrap_ch3", 64'(live[31:24]), 64'd0);
    check("wrap_ovf3", 64'(ovf[3]), 64'd1);
    cycle(4'b0000, 1'b1, 4'b1001, 1'b0, 1'b0);
    check("clr_ovf3", 64'(ovf[3]), 64'd0);

    // clear coinciding with an event on ch2
    for (int k = 0; k < 5; k++) cycle(4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0);
    check("ch2_five", 64'(live[23:16]), 64'd5);
    cycle(4'b0100, 1'b1, 4'b0100, 1'b0, 1'b0);
    check("clr_ev_ch2", 64'(live[23:16]), 64'd1);
    check("clr_ev_ovf2", 64'(ovf[2]), 64'd0);

    // atomic read-and-clear with an event in the snap cycle
    for (int k = 0; k < 3; k++) cycle(4'b1001, 1'b1, 4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cycle(4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0);
    cycle(4'b0001, 1'b1, 4'b0000, 1'b1, 1'b1);
    check("snap_shot0", 64'(shot[7:0]), 64'd7);
    check("snap_shot3", 64'(shot[31:24]), 64'd3);
    check("snap_live0", 64'(live[7:0]), 64'd1);
    check("snap_live3", 64'(live[31:24]), 64'd0);
    check("snap_stb", 64'(shot_stb), 64'd1);
    check("snap_vld", 64'(shot_vld), 64'd1);
    cycle(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);
    check("snap_stb_off", 64'(shot_stb), 64'd0);

    // snap_clr alone is ignored; back-to-back snaps without clear
    cycle(4'b0010, 1'b1, 4'b0000, 1'b0, 1'b1);
    cycle(4'b0010, 1'b1, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0010, 1'b1, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 1'b1, 4'b0010, 1'b0, 1'b0);

    // enable gating on ch1
    for (int k = 0; k < 5; k++) cycle(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0);
    check("en_off_ch1", 64'(live[15:8]), 64'd0);
    cycle(4'b0010, 1'b1, 4'b0000, 1'b0, 1'b0);
    check("en_on_ch1", 64'(live[15:8]), 64'd1);

    // random traffic
    for (int k = 0; k < 300; k++) begin
      logic [3:0] re, rc;
      logic rn, rs, rsc;
      re  = 4'($urandom);
      rn  = ($urandom_range(0, 3) != 0);
      rc  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      rs  = ($urandom_range(0, 4) == 0);
      rsc = 1'($urandom);
      cycle(re, rn, rc, rs, rsc);
    end

    // CW=4 wrap vs saturate on ch1
    sen = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      sev = 4'b0010;
      @(posedge clk);
      #1;
      $display("small k=%0d wrap=%h/%b sat=%h/%b", k, w_live, w_ovf, s_live, s_ovf);
      if (k == 15) begin
        check("w15_live", 64'(w_live[7:4]), 64'd15);
        check("w15_ovf", 64'(w_ovf[1]), 64'd0);
        check("s15_ovf", 64'(s_ovf[1]), 64'd0);
      end
      if (k == 16) begin
        check("w16_live", 64'(w_live[7:4]), 64'd0);
        check("w16_ovf", 64'(w_ovf[1]), 64'd1);
        check("s16_live", 64'(s_live[7:4]), 64'd15);
        check("s16_ovf", 64'(s_ovf[1]), 64'd1);
      end
      if (k == 17) begin
        check("w17_live", 64'(w_live), 64'h0010);
        check("w17_ovf", 64'(w_ovf), 64'b0010);
        check("s17_live", 64'(s_live), 64'h00F0);
        check("s17_ovf", 64'(s_ovf), 64'b0010);
      end
    end
    sev = 4'b0000;
    sclr = 4'b0010;
    @(posedge clk);
    #1;
    sclr = 4'b0000;
    $display("small clr wrap=%h/%b sat=%h/%b", w_live, w_ovf, s_live, s_ovf);
    check("s_clr_live", 64'(s_live), 64'd0);
    check("s_clr_ovf", 64'(s_ovf), 64'd0);
    sen = 1'b0;

    // reset between edges during a snap cycle
    cycle(4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0);
    cycle(4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0);
    ev = 4'b1111; en = 1'b1; snap = 1'b1;
    #3 rst = 1'b1;
    #1;
    $display("async rst live=%h shot=%h ovf=%b vld=%b stb=%b", live, shot, ovf, shot_vld, shot_stb);
    check("arst_live", 64'(live), 64'd0);
    check("arst_shot", 64'(shot), 64'd0);
    check("arst_ovf", 64'(ovf), 64'd0);
    check("arst_vld", 64'(shot_vld), 64'd0);
    check("arst_stb", 64'(shot_stb), 64'd0);
    @(posedge clk);
    #1;
    check("arst_hold_live", 64'(live), 64'd0);
    check("arst_hold_stb", 64'(shot_stb), 64'd0);
    rst = 1'b0; snap = 1'b0; ev = 4'b0000;
    model_reset();
    @(posedge clk);
    #1;
    check("post_rst_stb", 64'(shot_stb), 64'd0);
    check("post_rst_shot", 64'(shot), 64'd0);
    cycle(4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0);
    check("resume_ch2", 64'(live[23:16]), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/event_stats_bank.md
EVENT_STATS_BANK -- requirements
Module: event_stats_bank

Interface
REQ-001 SHALL have parameter NCH, default 4, number of event channels (1..32).
REQ-002 SHALL have parameter CW, default 8, counter width in bits (2..32).
REQ-003 SHALL have parameter SATURATE, default 0; 0 means counters wrap, 1 means counters saturate at 2^CW-1.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port ev  input  NCH  per-channel event strobe; one count per high cycle.
REQ-007 SHALL have port en  input  1  global count enable; ev is ignored while en=0.
REQ-008 SHALL have port clr  input  NCH  per-channel clear pulse, driven from regs_file pulse outputs.
REQ-009 SHALL have port snap  input  1  snapshot request, one-cycle pulse.
REQ-010 SHALL have port snap_clr  input  1  with snap, clears all live counters atomically.
REQ-011 SHALL have port live  output  NCH*CW  live counter values; channel i occupies bits [i*CW +: CW].
REQ-012 SHALL have port shot  output  NCH*CW  snapshot values, same packing as live.
REQ-013 SHALL have port ovf  output  NCH  sticky per-channel overflow flag.
REQ-014 SHALL have port shot_vld  output  1  high from the first snapshot until reset.
REQ-015 SHALL have port shot_stb  output  1  one-cycle strobe, asserted the cycle after a snapshot is taken.

Function
REQ-016 SHALL keep one CW-bit live counter per channel; all registers update on the rising edge of clk.
REQ-017 SHALL increment live[i] by 1 on each cycle with ev[i]=1 and en=1; SHALL hold it otherwise.
REQ-018 SHALL, with SATURATE=0, wrap live[i] from 2^CW-1 to 0 and set ovf[i] on that same edge.
REQ-019 SHALL, with SATURATE=1, hold live[i] at 2^CW-1 on further events and set ovf[i] on the first event seen at 2^CW-1.
REQ-020 SHALL, on clr[i]=1, load live[i] with 0 and clear ovf[i]; if ev[i]=1 and en=1 in the same cycle, it SHALL load 1 instead and leave ovf[i] at 0.
REQ-021 SHALL, on snap=1, copy all live counters into shot on the same edge, using their registered values from before that cycle's update.
REQ-022 SHALL NOT include in shot an event that occurs in the snap cycle; that event SHALL be counted in live.
REQ-023 SHALL, on snap=1 and snap_clr=1, clear all live counters on the same edge; events in that cycle SHALL leave the counter at 1; ovf SHALL be unchanged.
REQ-024 SHALL ignore snap_clr when snap=0.
REQ-025 SHALL apply clr[i] and snap_clr with the same priority: a cleared channel shows 0, or 1 if it had an event that cycle.
REQ-026 SHALL assert shot_stb for exactly one cycle, the cycle after each snap; back-to-back snaps SHALL give back-to-back strobes.
REQ-027 SHALL set shot_vld on the first snap and hold it until rst.
REQ-028 SHALL hold shot constant between snaps regardless of ev, clr or en.
REQ-029 SHALL have zero-cycle combinational paths only from registers to outputs; no input reaches an output combinationally.

Reset
REQ-030 SHALL, while rst=1, immediately force live=0, shot=0, ovf=0, shot_vld=0 and shot_stb=0, independent of clk.
REQ-031 SHALL ignore all inputs while rst=1 and resume counting on the first clk edge after rst deasserts.
REQ-032 SHALL, if rst asserts in a snap cycle, discard the snapshot: shot stays 0 and no shot_stb occurs.

Verification
REQ-033 Count: NCH=4, CW=8; drive ev[0] for 10 cycles with en=1 -> live ch0=10, other channels 0, ovf=0.
REQ-034 Wrap vs saturate: CW=4; drive 17 events on ch1.
- SATURATE=0 -> live ch1=1, ovf[1]=1.
- SATURATE=1 -> live ch1=15, ovf[1]=1.
REQ-035 Clear with event: live ch2=5; pulse clr[2] and ev[2] in the same cycle -> live ch2=1, ovf[2]=0.
REQ-036 Atomic read-clear: live ch0=7, ch3=3; pulse snap+snap_clr with ev[0]=1 ->
- shot ch0=7, shot ch3=3.
- next cycle: live ch0=1, live ch3=0.
- shot_stb=1 for one cycle; shot_vld=1.
REQ-037 Enable gating: en=0 with 5 ev[1] pulses -> live unchanged; en=1 restores counting on the next event.
REQ-038 Reset mid-operation: counters nonzero and snap issued; assert rst asynchronously between edges -> all outputs 0 immediately and no shot_stb afterwards.
